id_stage_pipe: RTL

- Registered, parametrised instruction-decode pipeline stage for the LoongArch32 core. Sits between the IF stage and the ID/EX pipeline register.
- Decodes a reduced integer subset (ADD.W, SUB.W, AND, OR, XOR, ADDI.W, ANDI, ORI, XORI, LU12I.W) into alusel/aluop plus resolved operands.
- Provides valid/ready handshaking, flush, EX/MEM bypass and load-use stall detection.

---
 rtl/id_stage_pipe_if.sv | 53 +++++
 rtl/id_stage_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe_if.sv
// Handshake/bus bundle for the ID stage: IF-side offer, regfile read port,
// EX/MEM forwarding taps, flush and the decoded output bundle.
interface id_stage_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8
) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_pc;
  logic [31:0]         in_inst;
  logic [REG_AW-1:0]   raddr1;
  logic [REG_AW-1:0]   raddr2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic                ex_we;
  logic [REG_AW-1:0]   ex_waddr;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_is_load;
  logic                mem_we;
  logic [REG_AW-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_pc;
  logic [ALUSEL_W-1:0] out_alusel;
  logic [ALUOP_W-1:0]  out_aluop;
  logic [DATA_W-1:0]   out_src1;
  logic [DATA_W-1:0]   out_src2;
  logic [REG_AW-1:0]   out_waddr;
  logic                out_we;
  logic                out_illegal;

  // Surrounding pipeline: drives the offer, regfile data and forwarding taps
  modport master (
    output in_valid, in_pc, in_inst, rdata1, rdata2,
           ex_we, ex_waddr, ex_wdata, ex_is_load,
           mem_we, mem_waddr, mem_wdata, flush, out_ready,
    input  in_ready, raddr1, raddr2, out_valid, out_pc, out_alusel,
           out_aluop, out_src1, out_src2, out_waddr, out_we, out_illegal
  );

  // The decode stage itself
  modport slave (
    input  in_valid, in_pc, in_inst, rdata1, rdata2,
           ex_we, ex_waddr, ex_wdata, ex_is_load,
           mem_we, mem_waddr, mem_wdata, flush, out_ready,
    output in_ready, raddr1, raddr2, out_valid, out_pc, out_alusel,
           out_aluop, out_src1, out_src2, out_waddr, out_we, out_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// LoongArch32 integer-subset decode stage with valid/ready, flush and load-use stall.
// Define ID_STAGE_BYPASS_EN for EX/MEM forwarding; otherwise any pending write to a used source stalls.
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_pipe_if.slave bus
);

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = '0;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(2);
  localparam logic [ALUOP_W-1:0]  OP_NOP    = '0;
  localparam logic [ALUOP_W-1:0]  OP_ADD    = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0]  OP_SUB    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0]  OP_AND    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0]  OP_OR     = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0]  OP_XOR    = ALUOP_W'(5);

  typedef struct packed {
    logic [31:0]         pc;
    logic [ALUSEL_W-1:0] alusel;
    logic [ALUOP_W-1:0]  aluop;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [REG_AW-1:0]   waddr;
    logic                we;
    logic                illegal;
  } bundle_t;

  logic [31:0]         inst;
  logic [REG_AW-1:0]   rd;
  logic                dec_legal;
  logic [ALUSEL_W-1:0] dec_sel;
  logic [ALUOP_W-1:0]  dec_op;
  logic                use_imm;
  logic                use_lui;
  logic [DATA_W-1:0]   imm;
  logic                use_src [2];
  logic [REG_AW-1:0]   raddr   [2];
  logic [DATA_W-1:0]   rdata   [2];
  logic [DATA_W-1:0]   opnd    [2];
  logic                hit_ex  [2];
  logic                hit_mem [2];
  logic                stall;
  logic                in_ready;
  logic                capture;
  logic                valid_q, valid_d;
  bundle_t             bundle_q, bundle_d;

  assign inst     = bus.in_inst;
  assign rd       = REG_AW'(inst[4:0]);
  assign raddr[0] = REG_AW'(inst[9:5]);
  assign raddr[1] = REG_AW'(inst[14:10]);
  assign rdata[0] = bus.rdata1;
  assign rdata[1] = bus.rdata2;

  // The three key fields never alias: register-register keys have inst[31:22] == 0
  always_comb begin
    dec_legal  = 1'b0;
    dec_sel    = SEL_NOP;
    dec_op     = OP_NOP;
    use_src[0] = 1'b0;
    use_src[1] = 1'b0;
    use_imm    = 1'b0;
    use_lui    = 1'b0;
    imm        = '0;
    case (inst[31:15])
      17'h00020: begin dec_legal = 1'b1; dec_sel = SEL_ARITH; dec_op = OP_ADD; end
      17'h00022: begin dec_legal = 1'b1; dec_sel = SEL_ARITH; dec_op = OP_SUB; end
      17'h00029: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_AND; end
      17'h0002A: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_OR;  end
      17'h0002B: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_XOR; end
      default: ;
    endcase
    if (dec_legal) begin
      use_src[0] = 1'b1;
      use_src[1] = 1'b1;
    end else begin
      case (inst[31:22])
        10'h00A: begin dec_legal = 1'b1; dec_sel = SEL_ARITH; dec_op = OP_ADD; end
        10'h00D: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_AND; end
        10'h00E: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_OR;  end
        10'h00F: begin dec_legal = 1'b1; dec_sel = SEL_LOGIC; dec_op = OP_XOR; end
        default: ;
      endcase
      if (dec_legal) begin
        use_src[0] = 1'b1;
        use_imm    = 1'b1;
        imm        = (inst[31:22] == 10'h00A) ? {{(DATA_W-12){inst[21]}}, inst[21:10]}
                                              : {{(DATA_W-12){1'b0}}, inst[21:10]};
      end else if (inst[31:25] == 7'h0A) begin
        dec_legal = 1'b1;
        dec_sel   = SEL_LOGIC;
        dec_op    = OP_OR;
        use_lui   = 1'b1;
        imm       = {{(DATA_W-31){inst[24]}}, inst[23:5], 12'b0};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign hit_ex[gi]  = use_src[gi] & bus.ex_we & (bus.ex_waddr == raddr[gi])
                         & (bus.ex_waddr != '0);
      assign hit_mem[gi] = use_src[gi] & bus.mem_we & (bus.mem_waddr == raddr[gi])
                         & (bus.mem_waddr != '0);
`ifdef ID_STAGE_BYPASS_EN
      assign opnd[gi] = (raddr[gi] == '0) ? '0 :
                        (bus.ex_we  && bus.ex_waddr  == raddr[gi]) ? bus.ex_wdata :
                        (bus.mem_we && bus.mem_waddr == raddr[gi]) ? bus.mem_wdata :
                        rdata[gi];
`else
      assign opnd[gi] = (raddr[gi] == '0) ? '0 : rdata[gi];
`endif
    end
  endgenerate

`ifdef ID_STAGE_BYPASS_EN
  // Only a load in EX cannot be forwarded in time
  logic unused_mem_hit;
  assign unused_mem_hit = hit_mem[0] | hit_mem[1];
  assign stall = bus.ex_is_load & (hit_ex[0] | hit_ex[1]);
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.ex_wdata, bus.mem_wdata, bus.ex_is_load};
  assign stall = hit_ex[0] | hit_ex[1] | hit_mem[0] | hit_mem[1];
`endif

  assign in_ready = ~stall & (~valid_q | bus.out_ready);
  assign capture  = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (bus.flush)
      valid_d = 1'b0;
    else if (capture)
      valid_d = 1'b1;
    else if (valid_q & bus.out_ready)
      valid_d = 1'b0;
    if (capture) begin
      bundle_d.pc      = bus.in_pc;
      bundle_d.alusel  = dec_sel;
      bundle_d.aluop   = dec_op;
      bundle_d.src1    = use_lui ? imm : (use_src[0] ? opnd[0] : '0);
      bundle_d.src2    = use_src[1] ? opnd[1] : (use_imm ? imm : '0);
      bundle_d.waddr   = rd;
      bundle_d.we      = dec_legal & (rd != '0);
      bundle_d.illegal = ~dec_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.raddr1      = raddr[0];
  assign bus.raddr2      = raddr[1];
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = bundle_q.pc;
  assign bus.out_alusel  = bundle_q.alusel;
  assign bus.out_aluop   = bundle_q.aluop;
  assign bus.out_src1    = bundle_q.src1;
  assign bus.out_src2    = bundle_q.src2;
  assign bus.out_waddr   = bundle_q.waddr;
  assign bus.out_we      = bundle_q.we;
  assign bus.out_illegal = bundle_q.illegal;

endmodule
